// File: rtl/demux_2bit_sel_buf_pkg.sv
// Shared constants for the 2-bit select demux slice.
// NUM_PORTS consumer ports, addressed by a SEL_W-bit select.
package demux_2bit_sel_buf_pkg;
  localparam int NUM_PORTS = 4;
  localparam int SEL_W     = 2;
endpackage

// File: rtl/demux_slot.sv
// One-entry output slot: data register plus valid flag.
// load refills (wins over deliver), valid&ready drains.
module demux_slot #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_2bit_sel_buf.sv
// Steers one producer stream to one of four buffered ports.
// Ports: CLK, RST_N, IN/sel/in_valid/in_ready, O0..O3/o_valid/o_ready.
module demux_2bit_sel_buf
  import demux_2bit_sel_buf_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [WIDTH-1:0]     IN,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     O0,
  output logic [WIDTH-1:0]     O1,
  output logic [WIDTH-1:0]     O2,
  output logic [WIDTH-1:0]     O3,
  output logic [NUM_PORTS-1:0] o_valid,
  input  logic [NUM_PORTS-1:0] o_ready
);

  logic [NUM_PORTS-1:0] dec;
  logic [NUM_PORTS-1:0] load;
  logic                 acc;
  logic [WIDTH-1:0]     slot_q [NUM_PORTS];

  always_comb begin
    dec = '0;
    case (sel)
      2'd0: dec[0] = 1'b1;
      2'd1: dec[1] = 1'b1;
      2'd2: dec[2] = 1'b1;
      2'd3: dec[3] = 1'b1;
      default: dec = '0;
    endcase
  end

  // Target slot free now, or draining this cycle.
  assign in_ready = RST_N
                  & (~o_valid[sel] | o_ready[sel]);
  assign acc  = in_valid & in_ready;
  assign load = dec & {NUM_PORTS{acc}};

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .CLK  (CLK),
      .RST_N(RST_N),
      .load (load[k]),
      .din  (IN),
      .ready(o_ready[k]),
      .valid(o_valid[k]),
      .dout (slot_q[k])
    );
  end

  assign O0 = slot_q[0];
  assign O1 = slot_q[1];
  assign O2 = slot_q[2];
  assign O3 = slot_q[3];

endmodule

// File: tb/tb_demux_2bit_sel_buf.sv
// Scoreboard bench for demux_2bit_sel_buf.
// Directed vectors then a long random run.
module tb_demux_2bit_sel_buf;

  logic        CLK;
  logic        RST_N;
  logic [31:0] IN;
  logic [1:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] O0, O1, O2, O3;
  logic [3:0]  o_valid;
  logic [3:0]  o_ready;

  int checks   = 0;
  int failures = 0;

  logic [31:0] q [4][$];
  logic [31:0] oa [4];

  assign oa[0] = O0;
  assign oa[1] = O1;
  assign oa[2] = O2;
  assign oa[3] = O3;

  demux_2bit_sel_buf #(.WIDTH(32)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .IN      (IN),
    .sel     (sel),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .O0      (O0),
    .O1      (O1),
    .O2      (O2),
    .O3      (O3),
    .o_valid (o_valid),
    .o_ready (o_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: compares DUT against per-port model queues
  // at every falling edge, then applies this cycle's
  // deliveries and accept to the model.
  initial begin
    logic exp_ir;
    int   s;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        chk("rst_ovalid", {28'd0, o_valid}, 32'd0);
        chk("rst_inready", {31'd0, in_ready}, 32'd0);
        for (int k = 0; k < 4; k++) begin
          chk("rst_data", oa[k], 32'd0);
          q[k].delete();
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          chk("mon_valid", {31'd0, o_valid[k]},
              {31'd0, q[k].size() != 0});
          if (q[k].size() != 0)
            chk("mon_data", oa[k], q[k][0]);
        end
        s = int'(sel);
        exp_ir = (q[s].size() == 0) || o_ready[s];
        chk("mon_inready", {31'd0, in_ready},
            {31'd0, exp_ir});
        for (int k = 0; k < 4; k++)
          if (q[k].size() != 0 && o_ready[k])
            void'(q[k].pop_front());
        if (in_valid && exp_ir)
          q[s].push_back(IN);
      end
    end
  end

  initial begin
    logic acc;
    RST_N    = 1'b0;
    in_valid = 1'b1;
    sel      = 2'd2;
    IN       = 32'hDEAD_BEEF;
    o_ready  = 4'b0000;

    // Reset holds everything clear despite a valid offer.
    repeat (3) step();
    chk("rst_v", {28'd0, o_valid}, 32'd0);
    chk("rst_ir", {31'd0, in_ready}, 32'd0);
    chk("rst_o2", O2, 32'd0);
    RST_N = 1'b1;
    step();
    chk("first_v", {28'd0, o_valid}, 32'h4);
    chk("first_o2", O2, 32'hDEAD_BEEF);
    in_valid = 1'b0;

    // Drain port 2, then fill port 1.
    o_ready = 4'b0100;
    step();
    o_ready  = 4'b0000;
    in_valid = 1'b1;
    sel      = 2'd1;
    IN       = 32'h1111;
    step();
    IN = 32'h2222;
    #1;
    chk("bp_ir", {31'd0, in_ready}, 32'd0);
    step();
    chk("bp_o1", O1, 32'h1111);
    in_valid = 1'b0;
    step();
    in_valid = 1'b1;
    sel      = 2'd3;
    IN       = 32'h3333;
    #1;
    chk("bp_ir3", {31'd0, in_ready}, 32'd1);
    step();
    chk("bp_v", {28'd0, o_valid}, 32'hA);
    chk("bp_o3", O3, 32'h3333);

    // Streaming on port 0 with all sinks ready.
    in_valid = 1'b0;
    o_ready  = 4'b1111;
    step();
    chk("drain_v", {28'd0, o_valid}, 32'd0);
    in_valid = 1'b1;
    sel      = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      IN = i;
      #1;
      chk("st_ir", {31'd0, in_ready}, 32'd1);
      step();
      chk("st_o0", O0, i);
      chk("st_v0", {31'd0, o_valid[0]}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("st_end", {31'd0, o_valid[0]}, 32'd0);

    // Refill port 0 while it drains; port 2 drains too.
    o_ready  = 4'b0000;
    in_valid = 1'b1;
    sel      = 2'd0;
    IN       = 32'hA0;
    step();
    sel = 2'd2;
    IN  = 32'hC2;
    step();
    sel     = 2'd0;
    IN      = 32'hB0;
    o_ready = 4'b0101;
    #1;
    chk("sim_ir", {31'd0, in_ready}, 32'd1);
    step();
    chk("sim_o0", O0, 32'hB0);
    chk("sim_v", {28'd0, o_valid}, 32'h1);

    // Fill all four, then reset between edges.
    o_ready = 4'b0000;
    in_valid = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      sel      = k[1:0];
      IN       = 10 * (k + 1);
      if (k == 0) o_ready = 4'b0001;
      step();
      o_ready = 4'b0000;
    end
    in_valid = 1'b0;
    chk("full_v", {28'd0, o_valid}, 32'hF);
    chk("full_o3", O3, 32'd40);
    #1;
    RST_N = 1'b0;
    #1;
    chk("mid_v", {28'd0, o_valid}, 32'd0);
    chk("mid_o0", O0, 32'd0);
    chk("mid_o1", O1, 32'd0);
    chk("mid_o3", O3, 32'd0);
    step();
    RST_N = 1'b1;
    step();

    // Random traffic; producer holds its offer until taken.
    acc = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        sel      = 2'($urandom);
        IN       = $urandom;
      end
      o_ready = 4'($urandom);
      @(negedge CLK);
      acc = in_valid & in_ready;
      step();
    end
    in_valid = 1'b0;
    o_ready  = 4'b1111;
    repeat (2) step();
    chk("end_v", {28'd0, o_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
